// File: rtl/fft_r2_sdf_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_r2_sdf_stage_if
// Purpose  : Streaming handshake bundle for one radix-2 SDF FFT stage.
//            The upstream side presents valid_i/data_i and receives ready_o.
//            The downstream side receives valid_o/data_o and presents ready_i.
// Revision : 1.0 - initial release
// ============================================================================
interface fft_r2_sdf_stage_if #(
  parameter int DW = 32
);
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          ready_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          ready_i;

  // Stage side of the bundle
  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o
  );

  // Environment side: feeds the input and consumes the result
  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o
  );
endinterface
`default_nettype wire

// File: rtl/fft_r2_sdf_stage.sv
`default_nettype none
// ============================================================================
// Module   : fft_r2_sdf_stage
// Purpose  : Radix-2 DIT FFT stage, single-path delay-feedback form.
//            A 2^STAGE word feedback buffer pairs samples S apart; the second
//            sample of each pair is rotated by a ROM twiddle, sums leave at
//            once and differences are parked in the buffer until the next
//            block's first half pushes them out.
// Revision : 1.0 - initial release
// ============================================================================
module fft_r2_sdf_stage #(
  parameter int STAGE = 0,
  parameter int DW    = 32,
  parameter int SCALE = 1
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  fft_r2_sdf_stage_if.slave strm
);

  localparam int W  = DW / 2;
  localparam int S  = 1 << STAGE;
  localparam int CW = STAGE + 1;
  // Index is at least one bit wide; for STAGE 0 the second entry is never used
  localparam int AW = (STAGE > 0) ? STAGE : 1;
  localparam int D  = 1 << AW;

  localparam logic signed [2*W:0] c_max = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] c_min = {{(W+2){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [2*W:0] c_rnd = (2*W+1)'(1) << (W - 2);

  logic [CW-1:0]        r_cnt;
  logic                 r_primed;
  logic                 r_valid;
  logic [DW-1:0]        r_data;
  logic [DW-1:0]        r_buf [D];

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_phase_b;
  logic [AW-1:0]        w_idx;
  logic [DW-1:0]        w_a;
  logic [DW-1:0]        w_t;
  logic [DW-1:0]        w_sum;
  logic [DW-1:0]        w_dif;
  logic signed [W-1:0]  w_a_re, w_a_im, w_t_re, w_t_im;
  logic signed [W:0]    w_sum_re, w_sum_im, w_dif_re, w_dif_im;

  // Clamp a wide signed value into the W-bit two's complement range
  function automatic logic [W-1:0] f_sat(input logic signed [2*W:0] v);
    logic [W-1:0] res;
    if (v > c_max) begin
      res = c_max[W-1:0];
    end else if (v < c_min) begin
      res = c_min[W-1:0];
    end else begin
      res = v[W-1:0];
    end
    return res;
  endfunction

  // Bring a W+1 bit butterfly component back to W bits (halve or saturate)
  function automatic logic [W-1:0] f_bfly(input logic signed [W:0] v);
    logic [W-1:0] res;
    if (SCALE != 0) begin
      res = v[W:1];
    end else begin
      res = f_sat((2*W+1)'(v));
    end
    return res;
  endfunction

  assign w_ready   = ~r_valid | strm.ready_i;
  assign w_accept  = strm.valid_i & w_ready;
  // cnt never exceeds 2S-1, so its top bit alone marks the second half
  assign w_phase_b = r_cnt[STAGE];

  generate
    if (STAGE == 0) begin : g_idx_single
      assign w_idx = '0;
    end else begin : g_idx_multi
      assign w_idx = r_cnt[STAGE-1:0];
    end
  endgenerate

  assign w_a    = r_buf[w_idx];
  assign w_a_re = w_a[DW-1:W];
  assign w_a_im = w_a[W-1:0];

  generate
    if (STAGE == 0) begin : g_no_mult
      // The only twiddle is W_0 = 1
      assign w_t = strm.data_i;
    end else begin : g_mult
      logic signed [W-1:0]  w_tw_re [S];
      logic signed [W-1:0]  w_tw_im [S];
      logic signed [W-1:0]  w_b_re, w_b_im, w_wr, w_wi;
      logic signed [2*W:0]  w_pr, w_pi;

      // Twiddle ROM: W_j = exp(-i*pi*j/S) at full-scale amplitude
      for (genvar gi = 0; gi < S; gi++) begin : g_rom
        localparam real c_amp  = real'(c_max);
        localparam real c_ang  = 3.14159265358979323846 * real'(gi) / real'(S);
        localparam real c_re_f = c_amp * $cos(c_ang);
        localparam real c_im_f = -c_amp * $sin(c_ang);
        localparam int  c_re   = (c_re_f >= 0.0) ? $rtoi(c_re_f + 0.5) : -$rtoi(0.5 - c_re_f);
        localparam int  c_im   = (c_im_f >= 0.0) ? $rtoi(c_im_f + 0.5) : -$rtoi(0.5 - c_im_f);
        assign w_tw_re[gi] = W'(c_re);
        assign w_tw_im[gi] = W'(c_im);
      end

      assign w_b_re = strm.data_i[DW-1:W];
      assign w_b_im = strm.data_i[W-1:0];
      assign w_wr   = w_tw_re[w_idx];
      assign w_wi   = w_tw_im[w_idx];

      // Full-precision complex product with round-half-up before rescaling
      assign w_pr = (2*W+1)'(w_b_re) * (2*W+1)'(w_wr)
                  - (2*W+1)'(w_b_im) * (2*W+1)'(w_wi) + c_rnd;
      assign w_pi = (2*W+1)'(w_b_re) * (2*W+1)'(w_wi)
                  + (2*W+1)'(w_b_im) * (2*W+1)'(w_wr) + c_rnd;

      // j = 0 passes b through untouched so the unit twiddle costs no precision
      assign w_t = (w_idx == '0) ? strm.data_i
                                 : {f_sat(w_pr >>> (W - 1)), f_sat(w_pi >>> (W - 1))};
    end
  endgenerate

  assign w_t_re   = w_t[DW-1:W];
  assign w_t_im   = w_t[W-1:0];
  assign w_sum_re = (W+1)'(w_a_re) + (W+1)'(w_t_re);
  assign w_sum_im = (W+1)'(w_a_im) + (W+1)'(w_t_im);
  assign w_dif_re = (W+1)'(w_a_re) - (W+1)'(w_t_re);
  assign w_dif_im = (W+1)'(w_a_im) - (W+1)'(w_t_im);
  assign w_sum    = {f_bfly(w_sum_re), f_bfly(w_sum_im)};
  assign w_dif    = {f_bfly(w_dif_re), f_bfly(w_dif_im)};

  // Block position, primed flag and the registered output word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_primed <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + CW'(1);
      if (w_phase_b) begin
        r_valid  <= 1'b1;
        r_data   <= w_sum;
        r_primed <= 1'b1;
      end else begin
        // First half pushes out the previous block's parked difference
        r_valid <= r_primed;
        if (r_primed) begin
          r_data <= w_a;
        end
      end
    end else if (w_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Feedback buffer: store new samples in the first half, differences in the second
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_buf[w_idx] <= w_phase_b ? w_dif : strm.data_i;
    end
  end

  assign strm.ready_o = w_ready;
  assign strm.valid_o = r_valid;
  assign strm.data_o  = r_data;

endmodule
`default_nettype wire
